// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an external dual-port RAM with combinational read.
// Words reach a registered output stage one edge after being written; capacity is RAM + 1.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ram_we,
  output logic [DATA_DEPTH-1:0] ram_aw,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic [DATA_DEPTH-1:0] ram_ar,
  input  logic [DATA_WIDTH-1:0] ram_qr,
  output logic [DATA_DEPTH:0]   level
);

  localparam int CAP = 1 << DATA_DEPTH;
  localparam logic [DATA_DEPTH:0] FULL = CAP[DATA_DEPTH:0];

  logic [DATA_DEPTH-1:0] wptr, rptr;
  logic [DATA_DEPTH:0]   ram_count, ram_count_nxt, level_nxt;
  logic                  push, load, out_valid_nxt;

  assign push = in_valid & in_ready & ~flush;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign load = (ram_count != '0) & (~out_valid | out_ready) & ~flush;

  assign ram_we = push;
  assign ram_aw = wptr;
  assign ram_d  = in_data;
  assign ram_ar = rptr;

  always_comb begin
    ram_count_nxt = ram_count;
    if (push && !load)
      ram_count_nxt = ram_count + 1'b1;
    else if (!push && load)
      ram_count_nxt = ram_count - 1'b1;

    out_valid_nxt = out_valid;
    if (load)
      out_valid_nxt = 1'b1;
    else if (out_valid && out_ready)
      out_valid_nxt = 1'b0;

    level_nxt = ram_count_nxt + {{DATA_DEPTH{1'b0}}, out_valid_nxt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_count <= '0;
      level     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else if (flush) begin
      // out_data is left stale; out_valid=0 already marks it meaningless.
      wptr      <= '0;
      rptr      <= '0;
      ram_count <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (load) begin
        rptr     <= rptr + 1'b1;
        out_data <= ram_qr;
      end
      ram_count <= ram_count_nxt;
      out_valid <= out_valid_nxt;
      level     <= level_nxt;
      in_ready  <= (ram_count_nxt != FULL);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed + random bench for ram_fifo_ctrl with a behavioural RAM and a reference queue.
module tb_ram_fifo_ctrl;

  logic        clk, rst, flush;
  logic [15:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready;
  logic        ram_we;
  logic [3:0]  ram_aw, ram_ar;
  logic [15:0] ram_d, ram_qr;
  logic [4:0]  level;

  logic [15:0] mem [16];
  logic [15:0] q [$];
  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int wraps  = 0;

  ram_fifo_ctrl #(.DATA_WIDTH(16), .DATA_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_we(ram_we), .ram_aw(ram_aw), .ram_d(ram_d),
    .ram_ar(ram_ar), .ram_qr(ram_qr), .level(level)
  );

  always @(posedge clk) if (ram_we) mem[ram_aw] <= ram_d;
  assign ram_qr = mem[ram_ar];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score the handshakes the coming edge will see, then compare level.
  task automatic tick();
    logic [15:0] e;
    #1;
    if (flush) begin
      check("flush_no_we", {31'd0, ram_we}, 32'd0);
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0)
          check("pop_empty", {31'd0, out_valid}, 32'd0);
        else begin
          e = q.pop_front();
          check("pop_data", {16'd0, out_data}, {16'd0, e});
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        n_push++;
        if (ram_aw == 4'hF) wraps++;
      end
    end
    @(posedge clk);
    #1;
    check("level", {27'd0, level}, q.size());
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((level != 0 || out_valid) && n < 60) begin
      tick();
      n++;
    end
    check("drain_level", {27'd0, level}, 32'd0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int start, cyc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset values while rst is held
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_level",     {27'd0, level},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("in_ready_rise", {31'd0, in_ready}, 32'd1);

    // back-to-back 1,2,3 with consumer always ready
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0001;
    tick();
    check("no_bypass", {31'd0, out_valid}, 32'd0);
    in_data = 16'h0002;
    tick();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data",  {16'd0, out_data},  32'h0001);
    in_data = 16'h0003;
    tick();
    check("b2b_second", {16'd0, out_data}, 32'h0002);
    in_valid = 1'b0;
    tick();
    check("b2b_third", {16'd0, out_data}, 32'h0003);
    drain();

    // fill to capacity with consumer stalled
    out_ready = 1'b0; in_valid = 1'b1;
    start = n_push;
    for (int i = 0; i < 22; i++) begin
      in_data = 16'h1000 + 16'(i);
      tick();
    end
    check("full_count",    n_push - start,    32'd17);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_level",    {27'd0, level},    32'd17);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("pop_frees_slot", {31'd0, in_ready}, 32'd1);

    // refill then sustained push+pop at the full boundary
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h2000;
    tick();
    check("refill_level", {27'd0, level}, 32'd17);
    wraps = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 16'h3000 + 16'(i);
      tick();
      check("stream_level", {31'd0, (level >= 5'd16 && level <= 5'd17)}, 32'd1);
    end
    check("wptr_wrap", {31'd0, (wraps >= 2)}, 32'd1);
    drain();

    // random traffic against the reference queue
    start = n_push; cyc = 0;
    while (n_push - start < 2000 && cyc < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      tick();
      cyc++;
    end
    check("rand_pushed", n_push - start, 32'd2000);
    drain();

    // flush with push and pop requested in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 16'h4000 + 16'(i);
      tick();
    end
    check("pre_flush_level", {27'd0, level}, 32'd9);
    flush = 1'b1; out_ready = 1'b1; in_data = 16'h5555;
    tick();
    check("flush_valid",    {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready},  32'd0);
    flush = 1'b0; in_data = 16'hBEEF;
    tick();
    check("post_flush_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    check("beef_valid", {31'd0, out_valid}, 32'd1);
    check("beef_data",  {16'd0, out_data},  32'hBEEF);
    drain();

    // asynchronous reset mid-burst
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'h6000 + 16'(i);
      tick();
    end
    check("pre_rst_level", {27'd0, level}, 32'd5);
    #3 rst = 1'b1;
    #1;
    check("arst_in_ready",  {31'd0, in_ready},  32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data",  {16'd0, out_data},  32'd0);
    check("arst_level",     {27'd0, level},     32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    in_data = 16'h1234; out_ready = 1'b1;
    tick();
    check("arst_ready_rise", {31'd0, in_ready},  32'd1);
    check("arst_no_data",    {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("arst_first_lat", {31'd0, out_valid}, 32'd0);
    tick();
    check("arst_first_valid", {31'd0, out_valid}, 32'd1);
    check("arst_first_data",  {16'd0, out_data},  32'h1234);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
